// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the BTB branch predictor.
// Holds the 2-bit counter encodings, the counter values used at reset and on
// allocation, the default index width, and the F->D->E pipeline payload type.
package branch_predictor_btb_pkg;

  localparam int IDX_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr_t;

  localparam ctr_t CTR_RESET = CTR_WEAK_NT;
  localparam ctr_t CTR_ALLOC = CTR_WEAK_T;

  // Lookup result carried alongside the instruction from fetch to execute.
  typedef struct packed {
    logic hit;
    logic pred;
  } pipe_t;

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// btb_sat_counter: next-state logic for a 2-bit saturating direction counter.
// Ports:
//   ctr      - current counter value
//   taken    - resolved branch outcome (1 = taken)
//   ctr_next - counter after the update (saturates at 00 and 11)
module btb_sat_counter
  import branch_predictor_btb_pkg::*;
(
  input  ctr_t ctr,
  input  logic taken,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_STRONG_T) ctr_next = ctr_t'(ctr + 2'd1);
    end else begin
      if (ctr != CTR_STRONG_NT) ctr_next = ctr_t'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped branch target buffer with 2-bit
// direction counters, a two-stage F->D->E hit/prediction pipeline and a
// saturating misprediction counter.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   pc_F                  - fetch PC looked up combinationally
//   stall, flush          - hazard controls for the F->D and D->E registers
//   branch_E, bne_E       - a conditional branch resolves in EX
//   pc_E, real_Value_E    - resolving PC and its actual outcome
//   target_E              - actual taken target
//   prediction_F          - predict taken for pc_F
//   predicted_target_F    - BTB target for pc_F, 0 on a miss
//   prediction_E, hit_E   - lookup result that travelled with the EX instruction
//   mispredict_count      - saturating count of mispredictions
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_F,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_E,
  input  logic            bne_E,
  input  logic [PC_W-1:0] pc_E,
  input  logic            real_Value_E,
  input  logic [PC_W-1:0] target_E,
  output logic            prediction_F,
  output logic [PC_W-1:0] predicted_target_F,
  output logic            prediction_E,
  output logic            hit_E,
  output logic [15:0]     mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = PC_W - IDX_W;

  logic            valid_reg  [DEPTH];
  logic [TAG_W-1:0] tag_reg   [DEPTH];
  logic [PC_W-1:0] target_reg [DEPTH];
  ctr_t            ctr_reg    [DEPTH];

  pipe_t       d_reg;
  pipe_t       e_reg;
  logic [15:0] mispredict_count_reg;

  // Fetch-side lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic             hit_f;
  ctr_t             ctr_f;

  assign idx_f = pc_F[IDX_W-1:0];
  assign tag_f = pc_F[PC_W-1:IDX_W];
  assign ctr_f = ctr_reg[idx_f];
  assign hit_f = valid_reg[idx_f] && (tag_reg[idx_f] == tag_f);

  assign prediction_F       = hit_f && (ctr_f == CTR_WEAK_T || ctr_f == CTR_STRONG_T);
  assign predicted_target_F = hit_f ? target_reg[idx_f] : '0;

  // Execute-side lookup and update decision
  logic [IDX_W-1:0] idx_e;
  logic [TAG_W-1:0] tag_e;
  logic             resolve;
  logic             hit_lookup_e;
  logic             upd_en;
  ctr_t             ctr_upd_e;
  logic             mispredict;

  assign idx_e        = pc_E[IDX_W-1:0];
  assign tag_e        = pc_E[PC_W-1:IDX_W];
  assign resolve      = branch_E | bne_E;
  assign hit_lookup_e = valid_reg[idx_e] && (tag_reg[idx_e] == tag_e);
  // A not-taken miss leaves the table untouched.
  assign upd_en       = resolve && (hit_lookup_e || real_Value_E);

  btb_sat_counter u_sat_counter (
    .ctr      (ctr_reg[idx_e]),
    .taken    (real_Value_E),
    .ctr_next (ctr_upd_e)
  );

  // Uses the prediction that travelled with the instruction, not a fresh lookup.
  assign mispredict = resolve &&
                      ((e_reg.pred != real_Value_E) || (real_Value_E && !e_reg.hit));

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg[gi]  <= 1'b0;
        tag_reg[gi]    <= '0;
        target_reg[gi] <= '0;
        ctr_reg[gi]    <= CTR_RESET;
      end else if (upd_en && (idx_e == IDX_W'(gi))) begin
        if (hit_lookup_e) begin
          ctr_reg[gi] <= ctr_upd_e;
          if (real_Value_E) target_reg[gi] <= target_E;
        end else begin
          valid_reg[gi]  <= 1'b1;
          tag_reg[gi]    <= tag_e;
          target_reg[gi] <= target_E;
          ctr_reg[gi]    <= CTR_ALLOC;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_reg                <= '0;
      e_reg                <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (flush) begin
        d_reg <= '0;
        e_reg <= '0;
      end else if (stall) begin
        // Decode holds its instruction; execute receives a bubble.
        e_reg <= '0;
      end else begin
        d_reg <= pipe_t'{hit: hit_f, pred: prediction_F};
        e_reg <= d_reg;
      end
      if (mispredict && (mispredict_count_reg != 16'hFFFF))
        mispredict_count_reg <= mispredict_count_reg + 16'd1;
    end
  end

  assign hit_E            = e_reg.hit;
  assign prediction_E     = e_reg.pred;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_F;
  logic        stall;
  logic        flush;
  logic        branch_E;
  logic        bne_E;
  logic [31:0] pc_E;
  logic        real_Value_E;
  logic [31:0] target_E;
  logic        prediction_F;
  logic [31:0] predicted_target_F;
  logic        prediction_E;
  logic        hit_E;
  logic [15:0] mispredict_count;

  always #5 clk = ~clk;

  branch_predictor_btb #(.PC_W(32), .IDX_W(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pc_F               (pc_F),
    .stall              (stall),
    .flush              (flush),
    .branch_E           (branch_E),
    .bne_E              (bne_E),
    .pc_E               (pc_E),
    .real_Value_E       (real_Value_E),
    .target_E           (target_E),
    .prediction_F       (prediction_F),
    .predicted_target_F (predicted_target_F),
    .prediction_E       (prediction_E),
    .hit_E              (hit_E),
    .mispredict_count   (mispredict_count)
  );

  typedef enum int {S_PF, S_TF, S_PE, S_HE, S_CNT} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Expectations pushed in a cycle are checked at that cycle's falling edge.
  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard at every falling edge and compares.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        S_PF:    act = {31'd0, prediction_F};
        S_TF:    act = predicted_target_F;
        S_PE:    act = {31'd0, prediction_E};
        S_HE:    act = {31'd0, hit_E};
        default: act = {16'd0, mispredict_count};
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
      end else begin
        $display("check %s = 0x%0h ok", e.name, act);
      end
    end
  end

  initial begin
    rst_n = 1'b0; pc_F = 32'h40; stall = 1'b0; flush = 1'b0;
    branch_E = 1'b0; bne_E = 1'b0; pc_E = '0; real_Value_E = 1'b0; target_E = '0;
    #1;
    chk("rst pred_F", S_PF, 0); chk("rst tgt_F", S_TF, 0);
    chk("rst pred_E", S_PE, 0); chk("rst hit_E", S_HE, 0); chk("rst count", S_CNT, 0);
    cyc();
    rst_n = 1'b1;

    // k0: cold lookup of 0x40
    chk("k0 pred_F", S_PF, 0); chk("k0 tgt_F", S_TF, 0); chk("k0 hit_E", S_HE, 0);
    cyc();
    // k1: resolve 0x40 taken -> allocate; same-cycle lookup sees old contents
    branch_E = 1'b1; pc_E = 32'h40; real_Value_E = 1'b1; target_E = 32'h80;
    chk("k1 pred_F pre-update", S_PF, 0); chk("k1 tgt_F pre-update", S_TF, 0);
    cyc();
    // k2: allocated entry, ctr=10
    branch_E = 1'b0;
    chk("k2 pred_F alloc", S_PF, 1); chk("k2 tgt_F alloc", S_TF, 32'h80);
    chk("k2 count", S_CNT, 1); chk("k2 hit_E", S_HE, 0);
    cyc();
    // k3: first not-taken
    branch_E = 1'b1; real_Value_E = 1'b0;
    chk("k3 pred_F ctr10", S_PF, 1); chk("k3 hit_E", S_HE, 0);
    cyc();
    // k4: second not-taken; E sees the k2 fetch
    chk("k4 pred_F ctr01", S_PF, 0); chk("k4 tgt_F", S_TF, 32'h80);
    chk("k4 hit_E", S_HE, 1); chk("k4 pred_E", S_PE, 1); chk("k4 count", S_CNT, 1);
    cyc();
    // k5: third not-taken, counter at 00
    chk("k5 pred_F ctr00", S_PF, 0); chk("k5 count", S_CNT, 2);
    cyc();
    // k6
    branch_E = 1'b0;
    chk("k6 pred_F ctr sat 00", S_PF, 0); chk("k6 hit_E", S_HE, 1);
    chk("k6 pred_E", S_PE, 0); chk("k6 count", S_CNT, 3);
    cyc();

    // Drain with misses
    pc_F = 32'h44;
    chk("k7 pred_F miss", S_PF, 0);
    cyc();
    cyc();
    // Stall: fetch 0x40, stall one cycle
    pc_F = 32'h40;
    chk("s0 hit_E", S_HE, 0);
    cyc();
    pc_F = 32'h44; stall = 1'b1;
    chk("s1 hit_E", S_HE, 0);
    cyc();
    stall = 1'b0;
    chk("s2 hit_E bubble", S_HE, 0);
    cyc();
    chk("s3 hit_E delayed", S_HE, 1);
    cyc();
    chk("s4 hit_E", S_HE, 0);
    cyc();

    // Flush wipes a hit in flight
    pc_F = 32'h40;
    cyc();
    pc_F = 32'h44; flush = 1'b1; stall = 1'b1;
    chk("f1 hit_E", S_HE, 0);
    cyc();
    flush = 1'b0; stall = 1'b0;
    chk("f2 hit_E flushed", S_HE, 0);
    cyc();
    chk("f3 hit_E flushed", S_HE, 0);
    cyc();

    // Replacement: 0x50 shares index with 0x40
    pc_F = 32'h40; branch_E = 1'b1; pc_E = 32'h50; real_Value_E = 1'b1; target_E = 32'h90;
    chk("r0 pred_F", S_PF, 0); chk("r0 tgt_F", S_TF, 32'h80); chk("r0 count", S_CNT, 3);
    cyc();
    branch_E = 1'b0;
    chk("r1 pred_F 0x40 evicted", S_PF, 0); chk("r1 tgt_F 0x40 evicted", S_TF, 0);
    chk("r1 count", S_CNT, 4);
    cyc();
    pc_F = 32'h50;
    chk("r2 pred_F 0x50", S_PF, 1); chk("r2 tgt_F 0x50", S_TF, 32'h90);
    cyc();
    // Taken on hit retargets; bne_E path
    bne_E = 1'b1; pc_E = 32'h50; real_Value_E = 1'b1; target_E = 32'hA0;
    chk("r3 tgt_F pre-update", S_TF, 32'h90);
    cyc();
    real_Value_E = 1'b0;
    chk("r4 tgt_F retarget", S_TF, 32'hA0); chk("r4 pred_F", S_PF, 1); chk("r4 count", S_CNT, 5);
    cyc();
    bne_E = 1'b0;
    chk("r5 pred_F ctr10", S_PF, 1); chk("r5 tgt_F", S_TF, 32'hA0);
    chk("r5 hit_E", S_HE, 1); chk("r5 pred_E", S_PE, 1); chk("r5 count", S_CNT, 6);
    cyc();

    // Reset mid-operation with a pending allocate
    rst_n = 1'b0; pc_F = 32'h60;
    branch_E = 1'b1; pc_E = 32'h60; real_Value_E = 1'b1; target_E = 32'h100;
    chk("m0 count reset", S_CNT, 0); chk("m0 pred_F", S_PF, 0);
    chk("m0 hit_E", S_HE, 0); chk("m0 pred_E", S_PE, 0);
    cyc();
    rst_n = 1'b1; branch_E = 1'b0;
    chk("m1 pred_F discarded", S_PF, 0); chk("m1 tgt_F discarded", S_TF, 0);
    cyc();
    pc_F = 32'h50;
    chk("m2 pred_F cleared", S_PF, 0); chk("m2 tgt_F cleared", S_TF, 0);
    cyc();

    // Saturation: every resolve is taken while hit_E is 0
    pc_F = 32'h44; branch_E = 1'b1; pc_E = 32'h7C; real_Value_E = 1'b1; target_E = 32'h200;
    repeat (65534) @(posedge clk);
    #1;
    branch_E = 1'b0; bne_E = 1'b1;
    chk("sat count FFFE", S_CNT, 32'hFFFE);
    cyc();
    chk("sat count FFFF", S_CNT, 32'hFFFF);
    cyc();
    chk("sat count hold 1", S_CNT, 32'hFFFF);
    cyc();
    bne_E = 1'b0;
    chk("sat count hold 2", S_CNT, 32'hFFFF);
    cyc();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
